// File: rtl/dmem_ctrl.sv
// Byte/half/word data memory with a valid/ready request/response handshake and fault reporting.
// Latency: LATENCY posedges from request accept to rsp_valid; one transaction outstanding.
// Backpressure: req_ready low in WAIT/RESP; RESP and its outputs hold until rsp_ready.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 32,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  // Word-organised storage; reset never touches it.
  logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

  logic          accept;
  logic          acc_err;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;
  logic [31:0]   rsp_rdata_d;

  // Decode the request: fault check, lane selection and load extension.
  always_comb begin
    accept   = req_valid && req_ready_q;
    acc_err  = (req_size == 2'b11) ||
               (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
               (req_addr >= ADDR_LIMIT);
    word_idx = req_addr[AW+1:2];
    rd_word  = mem_q[word_idx];
    rd_byte  = rd_word[{req_addr[1:0], 3'b000} +: 8];
    rd_half  = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (req_size)
      2'b00:   load_data = {{24{~req_unsigned & rd_byte[7]}}, rd_byte};
      2'b01:   load_data = {{16{~req_unsigned & rd_half[15]}}, rd_half};
      default: load_data = rd_word;
    endcase
    rsp_rdata_d = (acc_err || req_write) ? 32'h0 : load_data;
  end

  // Commit stores at the accept edge, touching only the addressed lanes.
  always_ff @(posedge clk) begin
    if (accept && req_write && !acc_err) begin
      case (req_size)
        2'b00: mem_q[word_idx][{req_addr[1:0], 3'b000} +: 8] <= req_wdata[7:0];
        2'b01: begin
          if (req_addr[1]) mem_q[word_idx][31:16] <= req_wdata[15:0];
          else             mem_q[word_idx][15:0]  <= req_wdata[15:0];
        end
        default: mem_q[word_idx] <= req_wdata;
      endcase
    end
  end

  // Transaction FSM with registered handshake outputs; the response is
  // captured at accept, so WAIT only counts the remaining edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= acc_err;
            req_ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              // Edges still to spend in WAIT after this one.
              state_q <= WAIT;
              cnt_q   <= 2'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
